// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: fixed-rate sample tick driving one MCP3002-style SPI frame per tick.
// Optional macro ADC_CH_SELECT_EN adds ch_sel, latched at frame start as the ODD (channel) bit.
module spi_adc_sampler #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5000,
    parameter int ADC_CHANNEL   = 0
) (
    input  logic       sysclk,
    input  logic       rst_n,
`ifdef ADC_CH_SELECT_EN
    input  logic       ch_sel,
`endif
    output logic       adc_cs_n,
    output logic       adc_sck,
    output logic       adc_mosi,
    input  logic       adc_miso,
    output logic [9:0] data_out,
    output logic       data_valid
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    state_t          state;
    logic [TW-1:0]   tmr;
    logic            tick;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      bit_cnt;
    logic [9:0]      shreg;
    logic            odd_bit;
    logic            div_end;
    logic            cap_en;

    assign tick    = (tmr == TICK_LAST);
    assign div_end = (div_cnt == DIV_LAST);
    // The rising edge that ends low phase k opens period k+1; periods 5..14 carry D9..D0.
    assign cap_en  = (bit_cnt >= 4'd4) && (bit_cnt <= 4'd13);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (tick) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TW'(1);
        end
    end

`ifdef ADC_CH_SELECT_EN
    logic ch_lat;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ch_lat <= 1'b0;
        end else if (state == IDLE && tick) begin
            ch_lat <= ch_sel;
        end
    end

    assign odd_bit = ch_lat;
`else
    localparam logic ODD_FIXED = 1'((ADC_CHANNEL % 2) != 0);

    assign odd_bit = ODD_FIXED;
`endif

    // Command per SCK period: start, SGL/DIFF, ODD, MSBF, then zeros.
    function automatic logic cmd_bit(input logic [4:0] k, input logic odd);
        case (k)
            5'd0, 5'd1, 5'd3: cmd_bit = 1'b1;
            5'd2:             cmd_bit = odd;
            default:          cmd_bit = 1'b0;
        endcase
    endfunction

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adc_cs_n   <= 1'b1;
            adc_sck    <= 1'b0;
            adc_mosi   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    data_valid <= 1'b0;
                    adc_cs_n   <= 1'b1;
                    adc_sck    <= 1'b0;
                    if (tick) begin
                        state    <= SETUP;
                        adc_cs_n <= 1'b0;
                        adc_mosi <= cmd_bit(5'd0, odd_bit);
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        state   <= SHIFT;
                        adc_sck <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (adc_sck) begin
                            adc_sck  <= 1'b0;
                            adc_mosi <= cmd_bit({1'b0, bit_cnt} + 5'd1, odd_bit);
                        end else if (bit_cnt == 4'd15) begin
                            state      <= DONE;
                            adc_cs_n   <= 1'b1;
                            adc_mosi   <= 1'b0;
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            adc_sck <= 1'b1;
                            if (cap_en) begin
                                shreg <= {shreg[8:0], adc_miso};
                            end
                        end
                    end
                end
                DONE: begin
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    adc_cs_n   <= 1'b1;
                    adc_sck    <= 1'b0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Bench for spi_adc_sampler: MCP3002-style ADC models on a default and a fast instance,
// scoreboard of words the models return, timing and protocol checks.
module tb_spi_adc_sampler;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic rst_n = 1'b1;
    logic rst_f = 1'b1;

    logic       cs_n, sck, mosi, miso, dv;
    logic [9:0] dout;
    logic       cs_f, sck_f, mosi_f, miso_f, dv_f;
    logic [9:0] dout_f;
`ifdef ADC_CH_SELECT_EN
    logic ch_sel   = 1'b0;
    logic ch_sel_f = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cyc, cs_fall_cyc, cs_fall_f, prev_dv, last_rises, dv_cnt;
    int rc   = 0;
    int rc_f = 0;
    logic [9:0] adc_word = 10'h000;
    logic [9:0] word_f   = 10'h1C3;
    logic [9:0] cur_w, cur_wf;
    logic       mbits[16];
    logic [9:0] exp_q[$];
    logic [9:0] exp_qf[$];

    spi_adc_sampler dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
`ifdef ADC_CH_SELECT_EN
        .ch_sel     (ch_sel),
`endif
        .adc_cs_n   (cs_n),
        .adc_sck    (sck),
        .adc_mosi   (mosi),
        .adc_miso   (miso),
        .data_out   (dout),
        .data_valid (dv)
    );

    spi_adc_sampler #(.CLK_DIV(1), .SAMPLE_PERIOD(36)) dut_f (
        .sysclk     (sysclk),
        .rst_n      (rst_f),
`ifdef ADC_CH_SELECT_EN
        .ch_sel     (ch_sel_f),
`endif
        .adc_cs_n   (cs_f),
        .adc_sck    (sck_f),
        .adc_mosi   (mosi_f),
        .adc_miso   (miso_f),
        .data_out   (dout_f),
        .data_valid (dv_f)
    );

    always @(posedge sysclk) cyc = cyc + 1;
    always @(negedge sysclk) if (dv) dv_cnt = dv_cnt + 1;

    // ADC model (default instance): conversion bits D9..D0 in periods 5..14, ones elsewhere.
    always @(negedge cs_n) begin
        rc = 0;
        cur_w = adc_word;
        for (int i = 0; i < 16; i++) mbits[i] = 1'b0;
        if (rst_n) begin
            exp_q.push_back(adc_word);
            cs_fall_cyc = cyc;
        end
    end
    always @(posedge sck) begin
        if (rc < 16) mbits[rc] = mosi;
        rc = rc + 1;
    end
    always @(posedge cs_n) last_rises = rc;
    assign miso = (!cs_n && rc >= 5 && rc <= 14) ? cur_w[4'(14 - rc)] : 1'b1;

    // ADC model (fast instance) with a fresh random word per frame.
    always @(negedge cs_f) begin
        rc_f = 0;
        cur_wf = word_f;
        if (rst_f) begin
            exp_qf.push_back(word_f);
            cs_fall_f = cyc;
        end
        word_f = 10'($urandom_range(0, 1023));
    end
    always @(posedge sck_f) rc_f = rc_f + 1;
    assign miso_f = (!cs_f && rc_f >= 5 && rc_f <= 14) ? cur_wf[4'(14 - rc_f)] : 1'b1;

    task automatic wait_valid(input bit fast, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (fast ? dv_f : dv) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_fall(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (!cs_n) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        rst_f = 1'b0;
        repeat (5) begin
            @(negedge sysclk);
            n_checks++;
            if ({cs_n, sck, mosi, dout, dv} !== {1'b1, 1'b0, 1'b0, 10'h000, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values: got cs_n=%b sck=%b mosi=%b data_out=%h dv=%b, expected 1 0 0 000 0", cs_n, sck, mosi, dout, dv);
            end
        end
        rst_n = 1'b1;
        rel_cyc = cyc;
        dv_cnt = 0;
    endtask

    task automatic test_single_frame();
        bit seen;
        logic [9:0] e;
        adc_word = 10'h2A5;
        wait_cs_fall(5100, seen);
        n_checks++;
        if (!seen || cyc - rel_cyc != 5000) begin
            n_fail++;
            $display("FAIL first_tick: cs_n fell %0d cycles after reset release, expected 5000", cyc - rel_cyc);
        end
        wait_valid(1'b0, 1000, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_timeout: no data_valid within 1000 cycles of cs_n falling");
            return;
        end
        n_checks++;
        if (cyc - cs_fall_cyc + 1 != 826) begin
            n_fail++;
            $display("FAIL valid_latency: data_valid %0d cycles after tick, expected 826", cyc - cs_fall_cyc + 1);
        end
        n_checks++;
        if ({mbits[0], mbits[1], mbits[2], mbits[3]} !== 4'b1101) begin
            n_fail++;
            $display("FAIL cmd_bits: got %b%b%b%b, expected 1101", mbits[0], mbits[1], mbits[2], mbits[3]);
        end
        n_checks++;
        if ({mbits[4], mbits[5], mbits[6], mbits[7], mbits[8], mbits[9], mbits[10], mbits[11],
             mbits[12], mbits[13], mbits[14], mbits[15]} !== 12'h000) begin
            n_fail++;
            $display("FAIL cmd_tail: mosi not zero during periods 4..15");
        end
        n_checks++;
        if (last_rises != 16) begin
            n_fail++;
            $display("FAIL sck_count: got %0d rising SCK edges in cs_n window, expected 16", last_rises);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL data_single: scoreboard empty, data_out=%h", dout);
        end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin
                n_fail++;
                $display("FAIL data_single: got %h expected %h", dout, e);
            end
        end
        prev_dv = cyc;
        @(negedge sysclk);
        n_checks++;
        if (dv !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_width: data_valid=%b one cycle after strobe, expected 0", dv);
        end
    endtask

    task automatic test_sequence();
        logic [9:0] words[3] = '{10'h000, 10'h3FF, 10'h200};
        logic [9:0] held, e;
        bit seen, stable;
        for (int i = 0; i < 3; i++) begin
            adc_word = words[i];
            held = dout;
            stable = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 5100; c++) begin
                @(negedge sysclk);
                if (dv) begin
                    seen = 1'b1;
                    break;
                end
                if (dout !== held) stable = 1'b0;
            end
            n_checks++;
            if (!stable) begin
                n_fail++;
                $display("FAIL data_hold: data_out changed between strobes (frame %0d), expected %h", i, held);
            end
            n_checks++;
            if (!seen || cyc - prev_dv != 5000) begin
                n_fail++;
                $display("FAIL valid_spacing: got %0d cycles between strobes, expected 5000", cyc - prev_dv);
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL data_seq: scoreboard empty, data_out=%h", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL data_seq: got %h expected %h", dout, e);
                end
            end
            prev_dv = cyc;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        int dv_before;
        logic [9:0] e;
        adc_word = 10'h155;
        wait_cs_fall(5100, seen);
        for (int i = 0; i < 1000 && rc < 10; i++) @(negedge sysclk);
        repeat (5) @(negedge sysclk);
        n_checks++;
        if (!seen || rc != 10 || sck !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_period9: rc=%0d sck=%b, expected 10 and 1", rc, sck);
        end
        dv_before = dv_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if ({cs_n, sck} !== 2'b10) begin
            n_fail++;
            $display("FAIL abort_now: got cs_n=%b sck=%b, expected 1 0", cs_n, sck);
        end
        repeat (100) @(negedge sysclk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        adc_word = 10'h0CA;
        wait_cs_fall(5100, seen);
        n_checks++;
        if (!seen || cyc - rel_cyc != 5000) begin
            n_fail++;
            $display("FAIL restart_tick: cs_n fell %0d cycles after release, expected 5000", cyc - rel_cyc);
        end
        n_checks++;
        if (dv_cnt != dv_before) begin
            n_fail++;
            $display("FAIL aborted_valid: got %0d strobes for aborted frame, expected 0", dv_cnt - dv_before);
        end
        wait_valid(1'b0, 1000, seen);
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL data_after_abort: seen=%0d queue=%0d, expected a strobe and one entry", seen, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (dout !== e || last_rises != 16) begin
                n_fail++;
                $display("FAIL data_after_abort: got %h (%0d sck) expected %h (16 sck)", dout, last_rises, e);
            end
        end
        prev_dv = cyc;
    endtask

    task automatic test_back_to_back();
        bit seen;
        int prev_f = 0;
        logic [9:0] e;
        @(negedge sysclk);
        rst_f = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(1'b1, 80, seen);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL fast_timeout: no data_valid within 80 cycles (frame %0d)", i);
                return;
            end
            n_checks++;
            if (cyc - cs_fall_f != 33 || (i > 0 && cyc - prev_f != 36)) begin
                n_fail++;
                $display("FAIL fast_timing: latency %0d spacing %0d, expected 33 and 36", cyc - cs_fall_f, cyc - prev_f);
            end
            n_checks++;
            if (exp_qf.size() == 0) begin
                n_fail++;
                $display("FAIL fast_data: scoreboard empty, data_out=%h", dout_f);
            end else begin
                e = exp_qf.pop_front();
                if (dout_f !== e) begin
                    n_fail++;
                    $display("FAIL fast_data: got %h expected %h", dout_f, e);
                end
            end
            prev_f = cyc;
        end
    endtask

`ifdef ADC_CH_SELECT_EN
    task automatic test_ch_sel();
        bit seen;
        logic [9:0] e;
        ch_sel = 1'b1;
        adc_word = 10'h31E;
        wait_cs_fall(5100, seen);
        for (int i = 0; i < 200 && rc < 1; i++) @(negedge sysclk);
        ch_sel = 1'b0;
        wait_valid(1'b0, 1000, seen);
        n_checks++;
        if (!seen || mbits[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_latched: got ODD=%b, expected 1", mbits[2]);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (dout !== e) begin
                n_fail++;
                $display("FAIL data_ch1: got %h expected %h", dout, e);
            end
        end
        adc_word = 10'h0E1;
        wait_cs_fall(5100, seen);
        wait_valid(1'b0, 1000, seen);
        n_checks++;
        if (!seen || mbits[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_next: got ODD=%b, expected 0", mbits[2]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_sequence();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef ADC_CH_SELECT_EN
        test_ch_sel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_adc_sampler.md
Name: spi_adc_sampler

Overview:
- Source end of the sample interface that the audio processors consume.
- Generates a fixed-rate sample tick from sysclk and runs one SPI conversion frame per tick against a 10-bit MCP3002-style ADC.
- Delivers the result as 10-bit offset-binary data_out, with a single-cycle data_valid strobe.
- Sits between the ADC pins and the processor's data_in/data_valid inputs.

Parameters:
- CLK_DIV, 25: sysclk cycles per SCK half-period (1 MHz SCK at 50 MHz); legal range >= 1.
- SAMPLE_PERIOD, 5000: sysclk cycles per sample tick (10 kHz at 50 MHz); must be > 33*CLK_DIV+2.
- ADC_CHANNEL, 0: fixed ADC channel (0/1) when ADC_CH_SELECT_EN is undefined.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sck  output  1  SPI clock, idle low (mode 0).
- adc_mosi  output  1  command bits to the ADC.
- adc_miso  input  1  conversion bits from the ADC.
- data_out  output  10  last converted sample, offset binary (512 = mid-scale).
- data_valid  output  1  one-cycle strobe; data_out is new in this cycle.

Behaviour:
- Reset values (asynchronous, immediate when rst_n=0): adc_cs_n=1, adc_sck=0, adc_mosi=0, data_out=0, data_valid=0, tick timer=0, FSM=IDLE, shift register=0.
- Tick timer:
  - Free-running, counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - tick=1 for one cycle when count = SAMPLE_PERIOD-1.
  - The timer never stalls.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE: cs_n=1, sck=0. On tick -> SETUP. A tick in any other state is dropped; no queueing.
  - SETUP: cs_n=0, sck=0, mosi=command bit 0. Lasts CLK_DIV cycles, then -> SHIFT.
  - SHIFT: 16 SCK periods k=0..15. Each period is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
    - adc_miso is sampled on the sysclk edge that drives sck 0->1.
    - mosi updates to bit k+1 on the edge that drives sck 1->0.
    - After the 16th low phase -> DONE.
  - DONE: one cycle. cs_n=1, data_out <= captured word, data_valid=1, then -> IDLE.
- Command bits (MOSI) for periods 0..3: start=1, SGL/DIFF=1, ODD=channel, MSBF=1. Periods 4..15: mosi=0.
- Capture:
  - Period 4 (null bit) is ignored.
  - Periods 5..14 capture D9..D0, MSB first.
  - Period 15 is ignored.
- Latency:
  - Tick in cycle T -> cs_n falls at T+1.
  - data_valid is high in cycle T+1+33*CLK_DIV only.
  - data_valid spacing is exactly SAMPLE_PERIOD cycles.
- data_out holds its value between strobes; it changes only in DONE.
- No arithmetic on the sample; offset removal is the consumer's job.
- Reset mid-frame:
  - Frame aborts immediately: cs_n=1, sck=0, no data_valid.
  - After release, the next frame starts only on a tick.
- Tick coincident with the DONE cycle: dropped, since the FSM is not IDLE. This cannot occur with legal parameters.

Optional Feature:
- Macro: ADC_CH_SELECT_EN.
- Defined:
  - Adds input port ch_sel (1 bit).
  - ch_sel is latched on the tick that starts the frame and drives the ODD bit.
  - Changes to ch_sel during a frame have no effect until the next frame.
- Undefined:
  - No ch_sel port.
  - ODD bit = ADC_CHANNEL[0] constant.

Test Plan:
1. Hold rst_n=0 for 5 cycles -> cs_n=1, sck=0, mosi=0, data_out=10'h000, data_valid=0 throughout.
2. CLK_DIV=25, ADC model returns 10'h2A5 -> mosi sampled on rising SCK edges 0..3 = 1,1,0,1; exactly 16 SCK rising edges per cs_n-low window; data_out=10'h2A5 with one data_valid pulse 826 cycles after the tick.
3. SAMPLE_PERIOD=5000, ADC model steps 10'h000, 10'h3FF, 10'h200 -> data_out follows in order; data_valid pulses exactly 5000 cycles apart; data_out stable between pulses.
4. Drop rst_n during SCK period 9, release 100 cycles later -> cs_n=1 and sck=0 at once, no data_valid for the aborted frame; next frame begins on the next tick and returns the model value correctly.
5. Override CLK_DIV=1, SAMPLE_PERIOD=36 -> back-to-back frames, data_valid every 36 cycles, no dropped frames.
6. ADC_CH_SELECT_EN defined, ch_sel=1 at tick then toggled to 0 mid-frame -> ODD bit=1 for that frame; the following frame has ODD=0.
